// File: rtl/hazard_tag_pkg.sv
// Shared result-source codes, opcode/funct constants and tag bundle
// for the decode-stage forwarding producer.
package hazard_tag_pkg;

  typedef enum logic [2:0] {
    RES_NW  = 3'b000,
    RES_ALU = 3'b001,
    RES_DM  = 3'b010,
    RES_PC  = 3'b011,
    RES_MD  = 3'b100
  } res_t;

  typedef enum logic [1:0] {
    TUSE_0    = 2'd0,
    TUSE_1    = 2'd1,
    TUSE_2    = 2'd2,
    TUSE_NONE = 2'd3
  } tuse_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_MFHI = 6'h10;
  localparam logic [5:0] FN_MTHI = 6'h11;
  localparam logic [5:0] FN_MFLO = 6'h12;
  localparam logic [5:0] FN_MTLO = 6'h13;
  localparam logic [5:0] FN_MULT = 6'h18;
  localparam logic [5:0] FN_DIV  = 6'h1a;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2a;

  typedef struct packed {
    logic [4:0]  a3;
    res_t        res;
    logic [31:0] pc8;
  } tag_t;

  localparam tag_t TAG_NONE = '{
    a3:  5'd0,
    res: RES_NW,
    pc8: 32'd0
  };

  // A used source stalls when its producer cannot deliver in time:
  // ALU/MD in E need one more cycle, DM in E two, DM in M one.
  // PC in E forwards at once, so it never stalls.
  function automatic logic src_stall(
    input logic [4:0] s,
    input tuse_t      tu,
    input tag_t       e,
    input tag_t       m
  );
    logic hit_e;
    logic hit_m;
    logic e_alu;
    hit_e = (s != 5'd0) && (s == e.a3);
    hit_m = (s != 5'd0) && (s == m.a3);
    e_alu = (e.res == RES_ALU) || (e.res == RES_MD);
    src_stall = 1'b0;
    if (tu != TUSE_NONE) begin
      src_stall =
        (hit_e && e_alu && (tu == TUSE_0)) ||
        (hit_e && (e.res == RES_DM) &&
         ((tu == TUSE_0) || (tu == TUSE_1))) ||
        (hit_m && (m.res == RES_DM) && (tu == TUSE_0));
    end
  endfunction

endpackage

// File: rtl/hazard_tag_pipe_decode.sv
// Combinational decode of the D-stage instruction into its
// destination tag, per-source Tuse and mult/div membership.
module hazard_tag_decode
  import hazard_tag_pkg::*;
#(
  parameter logic [4:0] RA_IDX = 5'd31
) (
  input  logic [31:0] ir,
  output logic [4:0]  a3,
  output res_t        res,
  output tuse_t       tuse_rs,
  output tuse_t       tuse_rt,
  output logic        md_op
);

  logic [5:0] op;
  logic [5:0] fn;
  logic [4:0] f_rs;
  logic [4:0] f_rt;
  logic [4:0] f_rd;
  logic       unused_shamt;

  assign op   = ir[31:26];
  assign fn   = ir[5:0];
  assign f_rs = ir[25:21];
  assign f_rt = ir[20:16];
  assign f_rd = ir[15:11];

  assign unused_shamt = ^ir[10:6];

  logic is_r;
  logic r_alu;
  logic r_sll;
  logic i_alu;
  logic i_lui;
  logic ld;
  logic st;
  logic br;
  logic jl;
  logic jr_i;
  logic jalr_i;
  logic mf;
  logic mt;
  logic muldiv;

  // Instruction class flags; at most one is set for any encoding.
  always_comb begin
    is_r   = (op == OP_RTYPE);
    r_alu  = is_r && ((fn == FN_ADDU) ||
                      (fn == FN_SUBU) ||
                      (fn == FN_AND)  ||
                      (fn == FN_OR)   ||
                      (fn == FN_SLT));
    r_sll  = is_r && (fn == FN_SLL);
    jr_i   = is_r && (fn == FN_JR);
    jalr_i = is_r && (fn == FN_JALR);
    mf     = is_r && ((fn == FN_MFHI) ||
                      (fn == FN_MFLO));
    mt     = is_r && ((fn == FN_MTHI) ||
                      (fn == FN_MTLO));
    muldiv = is_r && ((fn == FN_MULT) ||
                      (fn == FN_DIV));
    i_alu  = (op == OP_ORI) || (op == OP_ADDIU);
    i_lui  = (op == OP_LUI);
    ld     = (op == OP_LW);
    st     = (op == OP_SW);
    br     = (op == OP_BEQ) || (op == OP_BNE);
    jl     = (op == OP_JAL);
  end

  logic [4:0] a3_raw;
  res_t       res_raw;

  // Destination, result source and operand timing per class.
  always_comb begin
    a3_raw  = 5'd0;
    res_raw = RES_NW;
    tuse_rs = TUSE_NONE;
    tuse_rt = TUSE_NONE;
    unique case (1'b1)
      r_alu: begin
        a3_raw  = f_rd;
        res_raw = RES_ALU;
        tuse_rs = TUSE_1;
        tuse_rt = TUSE_1;
      end
      r_sll: begin
        a3_raw  = f_rd;
        res_raw = RES_ALU;
        tuse_rt = TUSE_1;
      end
      i_alu: begin
        a3_raw  = f_rt;
        res_raw = RES_ALU;
        tuse_rs = TUSE_1;
      end
      i_lui: begin
        a3_raw  = f_rt;
        res_raw = RES_ALU;
      end
      ld: begin
        a3_raw  = f_rt;
        res_raw = RES_DM;
        tuse_rs = TUSE_1;
      end
      st: begin
        tuse_rs = TUSE_1;
        tuse_rt = TUSE_2;
      end
      br: begin
        tuse_rs = TUSE_0;
        tuse_rt = TUSE_0;
      end
      jl: begin
        a3_raw  = RA_IDX;
        res_raw = RES_PC;
      end
      jr_i: begin
        tuse_rs = TUSE_0;
      end
      jalr_i: begin
        a3_raw  = f_rd;
        res_raw = RES_PC;
        tuse_rs = TUSE_0;
      end
      mf: begin
        a3_raw  = f_rd;
        res_raw = RES_MD;
      end
      mt: begin
        tuse_rs = TUSE_1;
      end
      muldiv: begin
        tuse_rs = TUSE_1;
        tuse_rt = TUSE_1;
      end
      default: begin
      end
    endcase
  end

  // Writes to $0 are discarded, so they carry no result.
  always_comb begin
    a3    = a3_raw;
    res   = (a3_raw == 5'd0) ? RES_NW : res_raw;
    md_op = mf || mt || muldiv;
  end

endmodule

// File: rtl/hazard_tag_pipe.sv
// Destination-tag pipeline E/M/W plus the stall for hazards the
// forwarding network cannot cover.
module hazard_tag_pipe
  import hazard_tag_pkg::*;
#(
  parameter logic [4:0] RA_IDX = 5'd31
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IR_D,
  input  logic [31:0] PC8_D,
  input  logic        md_busy,
  output logic        stall,
  output logic [4:0]  A3_E,
  output logic [4:0]  A3_M,
  output logic [4:0]  A3_W,
  output logic [2:0]  Res_E,
  output logic [2:0]  Res_M,
  output logic [2:0]  Res_W,
  output logic [31:0] PC8_E,
  output logic [31:0] PC8_M,
  output logic [31:0] PC8_W
);

  logic [4:0] dec_a3;
  res_t       dec_res;
  tuse_t      tuse_rs;
  tuse_t      tuse_rt;
  logic       md_op;

  hazard_tag_decode #(
    .RA_IDX (RA_IDX)
  ) u_dec (
    .ir      (IR_D),
    .a3      (dec_a3),
    .res     (dec_res),
    .tuse_rs (tuse_rs),
    .tuse_rt (tuse_rt),
    .md_op   (md_op)
  );

  tag_t e_q;
  tag_t m_q;
  tag_t w_q;
  tag_t e_d;
  tag_t m_d;
  tag_t w_d;

  logic hz_rs;
  logic hz_rt;
  logic hz_md;

  // Stall is the OR of both source hazards and the busy MD unit.
  always_comb begin
    hz_rs = src_stall(IR_D[25:21], tuse_rs, e_q, m_q);
    hz_rt = src_stall(IR_D[20:16], tuse_rt, e_q, m_q);
    hz_md = md_busy && md_op;
    stall = hz_rs || hz_rt || hz_md;
  end

  // A stall inserts a bubble into E; M and W always advance.
  always_comb begin
    e_d = stall ? TAG_NONE : '{
      a3:  dec_a3,
      res: dec_res,
      pc8: PC8_D
    };
    m_d = e_q;
    w_d = m_q;
  end

  // Tag pipeline registers, cleared at once on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_q <= TAG_NONE;
      m_q <= TAG_NONE;
      w_q <= TAG_NONE;
    end else begin
      e_q <= e_d;
      m_q <= m_d;
      w_q <= w_d;
    end
  end

  assign A3_E  = e_q.a3;
  assign A3_M  = m_q.a3;
  assign A3_W  = w_q.a3;
  assign Res_E = e_q.res;
  assign Res_M = m_q.res;
  assign Res_W = w_q.res;
  assign PC8_E = e_q.pc8;
  assign PC8_M = m_q.pc8;
  assign PC8_W = w_q.pc8;

endmodule

// File: tb/tb_hazard_tag_pipe.sv
// Directed bench for hazard_tag_pipe: tag flow through E/M/W,
// stall cases, bubbles and asynchronous reset.
module tb_hazard_tag_pipe;

  logic        clk;
  logic        reset;
  logic [31:0] IR_D;
  logic [31:0] PC8_D;
  logic        md_busy;
  logic        stall;
  logic [4:0]  A3_E;
  logic [4:0]  A3_M;
  logic [4:0]  A3_W;
  logic [2:0]  Res_E;
  logic [2:0]  Res_M;
  logic [2:0]  Res_W;
  logic [31:0] PC8_E;
  logic [31:0] PC8_M;
  logic [31:0] PC8_W;

  int n_assert;
  int n_fail;

  hazard_tag_pipe dut (
    .clk     (clk),
    .reset   (reset),
    .IR_D    (IR_D),
    .PC8_D   (PC8_D),
    .md_busy (md_busy),
    .stall   (stall),
    .A3_E    (A3_E),
    .A3_M    (A3_M),
    .A3_W    (A3_W),
    .Res_E   (Res_E),
    .Res_M   (Res_M),
    .Res_W   (Res_W),
    .PC8_E   (PC8_E),
    .PC8_M   (PC8_M),
    .PC8_W   (PC8_W)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rt_op(
    input logic [4:0] rs,
    input logic [4:0] rt,
    input logic [4:0] rd,
    input logic [5:0] fn
  );
    rt_op = {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] it_op(
    input logic [5:0]  op,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [15:0] imm
  );
    it_op = {op, rs, rt, imm};
  endfunction

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(
    input logic [31:0] ir,
    input logic [31:0] pc8
  );
    IR_D  = ir;
    PC8_D = pc8;
    #1;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    reset    = 1'b0;
    md_busy  = 1'b0;
    drive(32'h0, 32'h0);
    tick();
    tick();
    chk("rst_a3_e", {27'd0, A3_E}, 32'd0);
    chk("rst_res_w", {29'd0, Res_W}, 32'd0);
    chk("rst_pc8_m", PC8_M, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    reset = 1'b1;

    // jal: tag flows E -> M -> W
    drive(32'h0C000010, 32'h3008);
    chk("jal_stall", {31'd0, stall}, 32'd0);
    tick();
    chk("jal_a3_e", {27'd0, A3_E}, 32'd31);
    chk("jal_res_e", {29'd0, Res_E}, 32'd3);
    chk("jal_pc8_e", PC8_E, 32'h3008);
    drive(32'h0, 32'h300c);
    tick();
    chk("jal_a3_m", {27'd0, A3_M}, 32'd31);
    chk("jal_res_m", {29'd0, Res_M}, 32'd3);
    chk("jal_pc8_m", PC8_M, 32'h3008);
    chk("nop_res_e", {29'd0, Res_E}, 32'd0);
    tick();
    chk("jal_a3_w", {27'd0, A3_W}, 32'd31);
    chk("jal_pc8_w", PC8_W, 32'h3008);

    // lw $2 then addu $3,$2,$4
    drive(it_op(6'h23, 5'd1, 5'd2, 16'd0), 32'h3010);
    tick();
    drive(rt_op(5'd2, 5'd4, 5'd3, 6'h21), 32'h3014);
    chk("lwuse_stall", {31'd0, stall}, 32'd1);
    tick();
    chk("lwuse_bub_a3", {27'd0, A3_E}, 32'd0);
    chk("lwuse_bub_res", {29'd0, Res_E}, 32'd0);
    chk("lwuse_bub_pc8", PC8_E, 32'd0);
    chk("lwuse_res_m", {29'd0, Res_M}, 32'd2);
    chk("lwuse_rel", {31'd0, stall}, 32'd0);
    tick();
    chk("lwuse_a3_e", {27'd0, A3_E}, 32'd3);
    chk("lwuse_res_e", {29'd0, Res_E}, 32'd1);
    chk("lwuse_pc8_e", PC8_E, 32'h3014);

    // addu $5 then beq $5,$0
    drive(rt_op(5'd1, 5'd1, 5'd5, 6'h21), 32'h3018);
    tick();
    drive(it_op(6'h04, 5'd5, 5'd0, 16'd4), 32'h301c);
    chk("beq_stall", {31'd0, stall}, 32'd1);
    tick();
    chk("beq_rel", {31'd0, stall}, 32'd0);
    chk("beq_res_m", {29'd0, Res_M}, 32'd1);
    tick();
    chk("beq_a3_e", {27'd0, A3_E}, 32'd0);
    chk("beq_bub_m", {29'd0, Res_M}, 32'd0);
    chk("beq_a3_w", {27'd0, A3_W}, 32'd5);

    // lw $6 in M: sw $6 fine, jr $6 stalls
    drive(it_op(6'h23, 5'd1, 5'd6, 16'd0), 32'h3020);
    tick();
    drive(32'h0, 32'h3024);
    tick();
    drive(it_op(6'h2b, 5'd7, 5'd6, 16'd0), 32'h3028);
    chk("sw_m_stall", {31'd0, stall}, 32'd0);
    drive(rt_op(5'd6, 5'd0, 5'd0, 6'h08), 32'h3028);
    chk("jr_m_stall", {31'd0, stall}, 32'd1);
    drive(32'h0, 32'h3028);
    tick();

    // mult, then mflo $8 under md_busy
    drive(rt_op(5'd1, 5'd2, 5'd0, 6'h18), 32'h302c);
    tick();
    md_busy = 1'b1;
    drive(rt_op(5'd0, 5'd0, 5'd8, 6'h12), 32'h3030);
    chk("md_stall0", {31'd0, stall}, 32'd1);
    tick();
    chk("md_stall1", {31'd0, stall}, 32'd1);
    chk("md_bub_res", {29'd0, Res_E}, 32'd0);
    tick();
    chk("md_stall2", {31'd0, stall}, 32'd1);
    md_busy = 1'b0;
    #1;
    chk("md_rel", {31'd0, stall}, 32'd0);
    tick();
    chk("mflo_a3_e", {27'd0, A3_E}, 32'd8);
    chk("mflo_res_e", {29'd0, Res_E}, 32'd4);

    // MD in E: branch stalls, ALU consumer does not
    drive(it_op(6'h05, 5'd8, 5'd0, 16'd2), 32'h3034);
    chk("md_bne_stall", {31'd0, stall}, 32'd1);
    drive(rt_op(5'd8, 5'd1, 5'd9, 6'h21), 32'h3034);
    chk("md_addu_stall", {31'd0, stall}, 32'd0);

    // addu to $0
    drive(rt_op(5'd1, 5'd2, 5'd0, 6'h21), 32'h3038);
    tick();
    chk("zero_a3_e", {27'd0, A3_E}, 32'd0);
    chk("zero_res_e", {29'd0, Res_E}, 32'd0);

    // jal in E, jr $31 forwards PC
    drive(32'h0C000020, 32'h3040);
    tick();
    drive(rt_op(5'd31, 5'd0, 5'd0, 6'h08), 32'h3044);
    chk("pc_jr_stall", {31'd0, stall}, 32'd0);

    // lw $13 in E, addu uses it on rt
    drive(it_op(6'h23, 5'd1, 5'd13, 16'd8), 32'h3048);
    tick();
    drive(rt_op(5'd1, 5'd13, 5'd14, 6'h21), 32'h304c);
    chk("rt_lw_stall", {31'd0, stall}, 32'd1);

    // fill E/M/W with ALU tags, then async reset
    drive(rt_op(5'd1, 5'd1, 5'd10, 6'h21), 32'h3050);
    tick();
    drive(it_op(6'h0d, 5'd1, 5'd11, 16'h1), 32'h3054);
    tick();
    drive(rt_op(5'd1, 5'd1, 5'd12, 6'h23), 32'h3058);
    tick();
    drive(it_op(6'h04, 5'd12, 5'd0, 16'd1), 32'h305c);
    chk("pre_rst_stall", {31'd0, stall}, 32'd1);
    chk("pre_rst_a3_w", {27'd0, A3_W}, 32'd10);
    #1;
    reset = 1'b0;
    #1;
    chk("arst_a3_e", {27'd0, A3_E}, 32'd0);
    chk("arst_a3_m", {27'd0, A3_M}, 32'd0);
    chk("arst_a3_w", {27'd0, A3_W}, 32'd0);
    chk("arst_res_e", {29'd0, Res_E}, 32'd0);
    chk("arst_res_m", {29'd0, Res_M}, 32'd0);
    chk("arst_res_w", {29'd0, Res_W}, 32'd0);
    chk("arst_pc8_e", PC8_E, 32'd0);
    chk("arst_pc8_w", PC8_W, 32'd0);
    chk("arst_stall", {31'd0, stall}, 32'd0);
    reset = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_tag_pipe.md
Name: hazard_tag_pipe

Overview:
- Producer side of the decode-stage forwarding interface.
- Decodes the D-stage instruction into a destination tag (A3, Res) and carries the tag with PC8 through the E/M/W pipeline registers. The forwarding muxes consume A3_E/M/W, Res_E/M/W and PC8_E/M/W directly.
- Also generates the stall that covers hazards forwarding cannot resolve, inserting a bubble into E.

Parameters:
- RA_IDX, 31, register index written by jal.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- IR_D  input  32  instruction in D stage
- PC8_D  input  32  PC+8 of the D-stage instruction
- md_busy  input  1  multiply/divide unit busy (start cycle or counting)
- stall  output  1  combinational; hold PC/IF-ID, bubble into E
- A3_E, A3_M, A3_W  output  5 each  destination register per stage
- Res_E, Res_M, Res_W  output  3 each  result source per stage
- PC8_E, PC8_M, PC8_W  output  32 each  PC+8 per stage

Behaviour:
- Res encoding (shared): NW=3'b000, ALU=3'b001, DM=3'b010, PC=3'b011, MD=3'b100.
- Decode, combinational, on IR_D. R-type is op=0, keyed on funct.
  - addu 21, subu 23, and 24, or 25, slt 2a, sll 00: A3=rd, Res=ALU.
  - jalr 09: A3=rd, Res=PC.
  - mfhi 10, mflo 12: A3=rd, Res=MD.
  - ori 0d, lui 0f, addiu 09: A3=rt, Res=ALU.
  - lw 23: A3=rt, Res=DM.
  - jal 03: A3=RA_IDX, Res=PC.
  - All others (sw, beq, bne, j, jr, mult, div, mthi, mtlo, unknown): A3=0, Res=NW.
  - Whenever the decoded A3==0, force Res=NW (all-zero nop yields tag 0/NW).
- Tuse per source, rs=IR_D[25:21], rt=IR_D[20:16]:
  - Tuse=0: beq/bne rs,rt; jr/jalr rs.
  - Tuse=1: ALU-type rs, R-type ALU rt, lw/sw rs, mult/div rs,rt, mthi/mtlo rs.
  - Tuse=2: sw rt.
  - None: remaining fields.
- Tnew, implicit:
  - E: ALU/MD/PC=1, DM=2.
  - M: DM=1, others 0.
  - W: always 0.
  - Exception: PC in E forwards immediately (Tnew=0 for E-stage PC), matching the forwarding priority.
- stall=1 when, for a used source s!=0:
  - (s==A3_E and Res_E in {ALU,MD} and Tuse==0), or
  - (s==A3_E and Res_E==DM and Tuse<=1), or
  - (s==A3_M and Res_M==DM and Tuse==0), or
  - md_busy=1 and D is mult/div/mfhi/mflo/mthi/mtlo.
- Sequential, on posedge clk:
  - E <= stall ? {A3=0, Res=NW, PC8=0} : decoded D tag with PC8_D.
  - M <= E; W <= M, unconditionally (no stall of M/W).
- Reset, asynchronous on negedge reset: all A3=0, Res=NW, PC8=0 in E/M/W immediately. stall is combinational and follows the zeroed tags. A mid-operation reset discards all in-flight tags.
- Latency: the D tag appears at E one cycle after a non-stalled cycle, then M and W on the following cycles.
- Simultaneous hazards on rs and rt: stall is the OR of both.
- A bubble propagates as NW through M and W.
- Register 0 never causes a stall or a non-NW tag.

Decomposition:
- Shared package/header: Res codes NW/ALU/DM/PC/MD and opcode/funct constants. These are the same codes the forwarding muxes use, defined once.
- One sub-module, hazard_tag_decode: combinational decoding of IR_D to A3, Res, Tuse_rs, Tuse_rt, md_op.
- Top module holds the E/M/W registers and the stall compare.

Test Plan:
- Reset low mid-stream with E/M/W holding ALU tags: all tags read 0/NW and PC8 reads 0 without waiting for a clock; stall=0.
- jal (IR_D=0x0C000010, PC8_D=0x3008) with no stall: the next cycle shows A3_E=31, Res_E=PC, PC8_E=0x3008. It then reaches M, then W, on successive cycles.
- lw $2 in E, then D=addu $3,$2,$4: stall=1 for one cycle, E takes a bubble (0/NW). The next cycle has lw in M, stall=0, and addu enters E.
- addu $5 in E, then D=beq $5,$0: stall=1 for one cycle. The next cycle has ALU in M, stall=0.
- lw $6 in M, then D=sw $6,0($7): stall=0 (rt Tuse=2). D=jr $6 in the same situation: stall=1.
- mult in E with md_busy=1 and D=mflo $8: stall held for as long as md_busy=1. It releases in the cycle md_busy drops. D=addu $0 ($0 destination): A3_E=0, Res_E=NW.
